instr_fetch_unit: RTL and testbench

- Instruction-fetch stage for the MIPS core; sits directly upstream of the main decoder.
- Owns the PC and handshakes with a variable-latency instruction memory.
- Presents one instruction per issue slot; its opcode field drives the decoder's OP input.
- Resolves BranchEQ/BranchNE from the decoder plus the ALU zero flag to select the next PC.

---
 rtl/instr_fetch_unit.sv | 159 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches one word per issue slot from a
// variable-latency instruction memory and resolves BEQ/BNE for the next PC.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0040_0000,
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_eq,
    input  logic        branch_ne,
    input  logic        zero,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    output logic [31:0] retired_count,
    output logic        fetch_err
);

    localparam logic [15:0] WAIT_LIMIT_C = 16'(WAIT_LIMIT);
    localparam logic [31:0] RESET_PC_C   = {RESET_PC[31:2], 2'b00};
    localparam logic [5:0]  OPC_NONE     = 6'b111111;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_ISSUE = 2'd1,
        ST_ERROR = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic [31:0] instr_q, instr_d;
    logic        imem_req_q, imem_req_d;
    logic        instr_valid_q, instr_valid_d;
    logic [5:0]  opcode_q, opcode_d;
    logic [31:0] retired_count_q, retired_count_d;
    logic        fetch_err_q, fetch_err_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;

    logic        taken_s;
    logic [31:0] branch_target_s;
    logic [31:0] next_pc_s;
    logic [15:0] wait_inc_s;

    // Next-state and next-output computation for the fetch/issue sequencer
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        pc_plus4_d      = pc_plus4_q;
        instr_d         = instr_q;
        imem_req_d      = imem_req_q;
        instr_valid_d   = instr_valid_q;
        opcode_d        = opcode_q;
        retired_count_d = retired_count_q;
        fetch_err_d     = fetch_err_q;
        wait_cnt_d      = wait_cnt_q;

        taken_s         = (branch_eq & zero) | (branch_ne & ~zero);
        branch_target_s = pc_plus4_q + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        next_pc_s       = taken_s ? branch_target_s : pc_plus4_q;
        wait_inc_s      = wait_cnt_q + 16'd1;

        case (state_q)
            ST_FETCH: begin
                // The first FETCH cycle after reset has no request out, so ack is ignored there.
                if (imem_req_q && imem_ack) begin
                    instr_d       = imem_rdata;
                    opcode_d      = imem_rdata[31:26];
                    wait_cnt_d    = 16'd0;
                    imem_req_d    = 1'b0;
                    instr_valid_d = 1'b1;
                    state_d       = ST_ISSUE;
                end else if (imem_req_q) begin
                    wait_cnt_d = wait_inc_s;
                    if (wait_inc_s == WAIT_LIMIT_C) begin
                        imem_req_d  = 1'b0;
                        fetch_err_d = 1'b1;
                        state_d     = ST_ERROR;
                    end else begin
                        imem_req_d = 1'b1;
                    end
                end else begin
                    imem_req_d = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (!stall) begin
                    retired_count_d = retired_count_q + 32'd1;
                    pc_d            = next_pc_s;
                    pc_plus4_d      = next_pc_s + 32'd4;
                    instr_valid_d   = 1'b0;
                    opcode_d        = OPC_NONE;
                    imem_req_d      = 1'b1;
                    state_d         = ST_FETCH;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ERROR: begin
                imem_req_d    = 1'b0;
                instr_valid_d = 1'b0;
                opcode_d      = OPC_NONE;
                fetch_err_d   = 1'b1;
            end
            default: begin
                imem_req_d    = 1'b0;
                instr_valid_d = 1'b0;
                opcode_d      = OPC_NONE;
                fetch_err_d   = 1'b1;
                state_d       = ST_ERROR;
            end
        endcase
    end

    // State and registered outputs, synchronous reset dominates everything
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_FETCH;
            pc_q            <= RESET_PC_C;
            pc_plus4_q      <= RESET_PC_C + 32'd4;
            instr_q         <= 32'd0;
            imem_req_q      <= 1'b0;
            instr_valid_q   <= 1'b0;
            opcode_q        <= OPC_NONE;
            retired_count_q <= 32'd0;
            fetch_err_q     <= 1'b0;
            wait_cnt_q      <= 16'd0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            pc_plus4_q      <= pc_plus4_d;
            instr_q         <= instr_d;
            imem_req_q      <= imem_req_d;
            instr_valid_q   <= instr_valid_d;
            opcode_q        <= opcode_d;
            retired_count_q <= retired_count_d;
            fetch_err_q     <= fetch_err_d;
            wait_cnt_q      <= wait_cnt_d;
        end
    end

    assign imem_req      = imem_req_q;
    assign imem_addr     = pc_q;
    assign instr         = instr_q;
    assign opcode        = opcode_q;
    assign pc            = pc_q;
    assign pc_plus4      = pc_plus4_q;
    assign instr_valid   = instr_valid_q;
    assign retired_count = retired_count_q;
    assign fetch_err     = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: vector table, corner sequences and
// a randomized run against a behavioural reference model.
module tb_instr_fetch_unit;

    localparam int LIMIT = 4;

    logic        clk;
    logic        reset;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_eq;
    logic        branch_ne;
    logic        zero;

    logic        imem_req, instr_valid, fetch_err;
    logic [31:0] imem_addr, instr, pc, pc_plus4, retired_count;
    logic [5:0]  opcode;

    logic        w_req, w_valid, w_err;
    logic [31:0] w_addr, w_instr, w_pc, w_pc_plus4, w_retired;
    logic [5:0]  w_opcode;

    int total = 0;
    int bad   = 0;

    instr_fetch_unit #(.RESET_PC(32'h0040_0000), .WAIT_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
        .branch_eq(branch_eq), .branch_ne(branch_ne), .zero(zero),
        .instr(instr), .opcode(opcode), .pc(pc), .pc_plus4(pc_plus4),
        .instr_valid(instr_valid), .retired_count(retired_count), .fetch_err(fetch_err)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset), .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
        .branch_eq(branch_eq), .branch_ne(branch_ne), .zero(zero),
        .instr(w_instr), .opcode(w_opcode), .pc(w_pc), .pc_plus4(w_pc_plus4),
        .instr_valid(w_valid), .retired_count(w_retired), .fetch_err(w_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          rst;
        int          n_wait;
        int          n_stall;
        logic [31:0] rdata;
        bit          beq;
        bit          bne;
        bit          zr;
        logic [31:0] exp_pc;
        logic [5:0]  exp_op;
        logic [31:0] exp_after;
    } vec_t;

    vec_t        tbl[12];
    logic [31:0] exp_ret;

    // reference model state
    int          m_phase;   // 0 fetch, 1 issue, 2 error
    bit          m_req;
    bit          m_err;
    int          m_wait;
    logic [31:0] m_pc, m_instr, m_ret;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; imem_ack = 1'b0; stall = 1'b0;
        branch_eq = 1'b0; branch_ne = 1'b0; zero = 1'b0;
        step();
        reset = 1'b0;
        exp_ret = 32'd0;
    endtask

    task automatic wait_req();
        int n = 0;
        while (imem_req !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        chk("req_up", {31'd0, imem_req}, 32'd1);
    endtask

    task automatic run_rec(input vec_t v);
        if (v.rst) begin
            do_reset();
            chk("rst_pc", pc, 32'h0040_0000);
            chk("rst_req", {31'd0, imem_req}, 32'd0);
            chk("rst_valid", {31'd0, instr_valid}, 32'd0);
            chk("rst_opcode", {26'd0, opcode}, 32'h3F);
            chk("rst_instr", instr, 32'd0);
            chk("rst_retired", retired_count, 32'd0);
            chk("rst_err", {31'd0, fetch_err}, 32'd0);
        end
        wait_req();
        chk("fetch_addr", imem_addr, v.exp_pc);
        for (int w = 0; w < v.n_wait; w++) begin
            imem_ack = 1'b0;
            step();
        end
        imem_ack = 1'b1; imem_rdata = v.rdata;
        step();
        imem_ack = 1'b0; imem_rdata = $urandom;
        chk("issue_valid", {31'd0, instr_valid}, 32'd1);
        chk("issue_opcode", {26'd0, opcode}, {26'd0, v.exp_op});
        chk("issue_instr", instr, v.rdata);
        chk("issue_pc", pc, v.exp_pc);
        chk("issue_pc4", pc_plus4, v.exp_pc + 32'd4);
        branch_eq = v.beq; branch_ne = v.bne; zero = v.zr;
        for (int s = 0; s < v.n_stall; s++) begin
            stall = 1'b1;
            step();
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_pc", pc, v.exp_pc);
            chk("stall_retired", retired_count, exp_ret);
        end
        stall = 1'b0;
        step();
        branch_eq = 1'b0; branch_ne = 1'b0; zero = 1'b0;
        exp_ret = exp_ret + 32'd1;
        chk("next_pc", pc, v.exp_after);
        chk("retired", retired_count, exp_ret);
        chk("post_valid", {31'd0, instr_valid}, 32'd0);
        chk("post_opcode", {26'd0, opcode}, 32'h3F);
        chk("post_req", {31'd0, imem_req}, 32'd1);
    endtask

    task automatic model_reset();
        m_phase = 0; m_req = 1'b0; m_err = 1'b0; m_wait = 0;
        m_pc = 32'h0040_0000; m_instr = 32'd0; m_ret = 32'd0;
    endtask

    // advance the reference model by one clock edge given the inputs at that edge
    task automatic model_step(input bit rst, input bit ack, input logic [31:0] rd,
                              input bit stl, input bit beq, input bit bne, input bit zr);
        logic signed [15:0] imm;
        int                 off;
        if (rst) begin
            model_reset();
        end else if (m_phase == 0) begin
            if (!m_req) begin
                m_req = 1'b1;
            end else if (ack) begin
                m_instr = rd; m_wait = 0; m_phase = 1; m_req = 1'b0;
            end else begin
                m_wait++;
                if (m_wait >= LIMIT) begin
                    m_phase = 2; m_req = 1'b0; m_err = 1'b1;
                end
            end
        end else if (m_phase == 1) begin
            if (!stl) begin
                imm = m_instr[15:0];
                off = ((beq && zr) || (bne && !zr)) ? int'(imm) * 4 : 0;
                m_pc = m_pc + 32'd4 + 32'(off);
                m_ret = m_ret + 32'd1;
                m_phase = 0; m_req = 1'b1;
            end
        end
    endtask

    initial begin
        int          nreq, nval, nsteps;
        logic [31:0] pc_hold, ret0, op_exp;
        logic [168:0] act_bus, exp_bus;
        bit          r_rst, r_ack, r_stl, r_beq, r_bne, r_zr;
        logic [31:0] r_rd;

        reset = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0; stall = 1'b0;
        branch_eq = 1'b0; branch_ne = 1'b0; zero = 1'b0; exp_ret = 32'd0;

        tbl[0]  = '{1'b1, 0, 0, 32'h2008_0005, 1'b0, 1'b0, 1'b0, 32'h0040_0000, 6'h08, 32'h0040_0004};
        tbl[1]  = '{1'b0, 1, 0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0040_0004, 6'h00, 32'h0040_0008};
        tbl[2]  = '{1'b0, 0, 1, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'h0040_0008, 6'h00, 32'h0040_000C};
        tbl[3]  = '{1'b0, 2, 0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0040_000C, 6'h00, 32'h0040_0010};
        tbl[4]  = '{1'b0, 0, 0, 32'h1000_0003, 1'b1, 1'b0, 1'b1, 32'h0040_0010, 6'h04, 32'h0040_0020};
        tbl[5]  = '{1'b0, 0, 0, 32'h1000_0003, 1'b1, 1'b0, 1'b0, 32'h0040_0020, 6'h04, 32'h0040_0024};
        tbl[6]  = '{1'b0, 0, 0, 32'h1400_FFFF, 1'b0, 1'b1, 1'b0, 32'h0040_0024, 6'h05, 32'h0040_0024};
        tbl[7]  = '{1'b0, 0, 2, 32'h1400_FFFF, 1'b0, 1'b1, 1'b1, 32'h0040_0024, 6'h05, 32'h0040_0028};
        tbl[8]  = '{1'b0, 3, 2, 32'h1000_0003, 1'b0, 1'b0, 1'b1, 32'h0040_0028, 6'h04, 32'h0040_002C};
        tbl[9]  = '{1'b0, 1, 0, 32'h1000_0002, 1'b1, 1'b1, 1'b0, 32'h0040_002C, 6'h04, 32'h0040_0038};
        tbl[10] = '{1'b1, 0, 0, 32'h8C00_0000, 1'b0, 1'b0, 1'b0, 32'h0040_0000, 6'h23, 32'h0040_0004};
        tbl[11] = '{1'b0, 0, 1, 32'h1000_8000, 1'b1, 1'b0, 1'b1, 32'h0040_0004, 6'h04, 32'h003E_0008};

        for (int i = 0; i < 12; i++) run_rec(tbl[i]);

        // ack after 3 waits, then 2 stall cycles: 4 request cycles, 3 issue cycles
        ret0 = retired_count; nreq = 0; nval = 0; pc_hold = pc;
        for (int k = 0; k < 7; k++) begin
            nreq += int'(imem_req);
            nval += int'(instr_valid);
            if (k == 5) chk("seq_stall_pc", pc, pc_hold);
            imem_ack   = (k == 3);
            imem_rdata = 32'h2008_0005;
            stall      = (k == 4 || k == 5);
            step();
        end
        imem_ack = 1'b0; stall = 1'b0;
        chk("seq_req_cycles", nreq, 32'd4);
        chk("seq_valid_cycles", nval, 32'd3);
        chk("seq_retired", retired_count, ret0 + 32'd1);
        chk("seq_pc", pc, pc_hold + 32'd4);

        // timeout with no ack, ack afterwards ignored
        do_reset();
        nreq = 0; nsteps = 0;
        while (fetch_err !== 1'b1 && nsteps < 20) begin
            nreq += int'(imem_req);
            step();
            nsteps++;
        end
        chk("to_err", {31'd0, fetch_err}, 32'd1);
        chk("to_req_cycles", nreq, LIMIT);
        chk("to_req_low", {31'd0, imem_req}, 32'd0);
        imem_ack = 1'b1; imem_rdata = 32'h2008_0005;
        for (int k = 0; k < 3; k++) step();
        imem_ack = 1'b0;
        chk("to_ack_ignored_valid", {31'd0, instr_valid}, 32'd0);
        chk("to_ack_ignored_instr", instr, 32'd0);
        chk("to_err_sticky", {31'd0, fetch_err}, 32'd1);
        chk("to_opcode", {26'd0, opcode}, 32'h3F);
        do_reset();
        chk("to_clr_err", {31'd0, fetch_err}, 32'd0);
        chk("to_clr_pc", pc, 32'h0040_0000);

        // reset mid-FETCH with request high
        wait_req();
        reset = 1'b1; step(); reset = 1'b0;
        chk("rf_req", {31'd0, imem_req}, 32'd0);
        chk("rf_pc", pc, 32'h0040_0000);

        // reset mid-ISSUE after one retire
        wait_req();
        imem_ack = 1'b1; imem_rdata = 32'h0000_0000; step();
        imem_ack = 1'b0; step();
        wait_req();
        imem_ack = 1'b1; imem_rdata = 32'h2008_0005; step();
        imem_ack = 1'b0; stall = 1'b1;
        chk("ri_in_issue", {31'd0, instr_valid}, 32'd1);
        chk("ri_pc_before", pc, 32'h0040_0004);
        reset = 1'b1; step(); reset = 1'b0; stall = 1'b0;
        chk("ri_valid", {31'd0, instr_valid}, 32'd0);
        chk("ri_opcode", {26'd0, opcode}, 32'h3F);
        chk("ri_pc", pc, 32'h0040_0000);
        chk("ri_retired", retired_count, 32'd0);
        chk("ri_req", {31'd0, imem_req}, 32'd0);

        // PC wrap at top of address space
        do_reset();
        chk("wrap_rst_pc", w_pc, 32'hFFFF_FFFC);
        chk("wrap_rst_pc4", w_pc_plus4, 32'h0000_0000);
        nsteps = 0;
        while (w_req !== 1'b1 && nsteps < 8) begin
            step();
            nsteps++;
        end
        chk("wrap_addr", w_addr, 32'hFFFF_FFFC);
        imem_ack = 1'b1; imem_rdata = 32'h2008_0005; step(); imem_ack = 1'b0;
        chk("wrap_valid", {31'd0, w_valid}, 32'd1);
        step();
        chk("wrap_pc", w_pc, 32'h0000_0000);
        chk("wrap_retired", w_retired, 32'd1);

        // randomized run against the reference model
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            op_exp  = (m_phase == 1) ? {26'd0, m_instr[31:26]} : 32'h3F;
            act_bus = {imem_req, imem_addr, instr_valid, opcode, instr, pc, pc_plus4, retired_count, fetch_err};
            exp_bus = {m_req, m_pc, (m_phase == 1), op_exp[5:0], m_instr, m_pc, m_pc + 32'd4, m_ret, m_err};
            total++;
            if (act_bus !== exp_bus) begin
                bad++;
                $display("FAIL rand_cycle_%0d: got %h expected %h", c, act_bus, exp_bus);
            end
            r_rst = m_err ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 299) == 0);
            r_ack = $urandom_range(0, 2) != 0;
            r_stl = $urandom_range(0, 2) == 0;
            r_beq = $urandom_range(0, 1) == 1;
            r_bne = $urandom_range(0, 1) == 1;
            r_zr  = $urandom_range(0, 1) == 1;
            r_rd  = $urandom;
            reset = r_rst; imem_ack = r_ack; imem_rdata = r_rd; stall = r_stl;
            branch_eq = r_beq; branch_ne = r_bne; zero = r_zr;
            model_step(r_rst, r_ack, r_rd, r_stl, r_beq, r_bne, r_zr);
            step();
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
